// File: rtl/count_monitor.sv
// Passive observer for an up/down counter: classifies each accepted sample,
// keeps saturating wrap/jump statistics and raises a sticky, acknowledged alarm.
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int EVW    = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             updown,
    input  logic             alarm_ack,
    input  logic             clr_stats,
    output logic [WIDTH-1:0] last_cnt,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             jump_pulse,
    output logic [EVW-1:0]   ovf_count,
    output logic [EVW-1:0]   unf_count,
    output logic [EVW-1:0]   jump_count,
    output logic             alarm
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] ALARM = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [EVW-1:0]   EV_MAX  = '1;
    localparam logic [EVW-1:0]   THR     = EVW'(THRESH);

    logic [1:0]       state;
    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             in_seq;
    logic             is_ovf;
    logic             is_unf;
    logic             is_jump;
    logic [EVW-1:0]   ovf_inc;
    logic [EVW-1:0]   unf_inc;
    logic [EVW-1:0]   jump_inc;
    logic             trigger;

    always_comb begin
        expected = updown ? last_cnt + 1'b1 : last_cnt - 1'b1;
        accept   = cnt_valid && (state != EMPTY);
        in_seq   = (cnt_in == expected);
        is_ovf   = accept && in_seq && updown && (last_cnt == CNT_MAX);
        is_unf   = accept && in_seq && !updown && (last_cnt == '0);
        is_jump  = accept && !in_seq;
        ovf_inc  = (ovf_count == EV_MAX) ? ovf_count : ovf_count + 1'b1;
        unf_inc  = (unf_count == EV_MAX) ? unf_count : unf_count + 1'b1;
        jump_inc = (jump_count == EV_MAX) ? jump_count : jump_count + 1'b1;
        // Threshold is judged on the post-increment count of the same event
        trigger  = (is_ovf && (ovf_inc >= THR)) || (is_unf && (unf_inc >= THR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            last_cnt   <= '0;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            jump_pulse <= 1'b0;
            ovf_count  <= '0;
            unf_count  <= '0;
            jump_count <= '0;
            alarm      <= 1'b0;
        end else if (clr_stats) begin
            state      <= EMPTY;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            jump_pulse <= 1'b0;
            ovf_count  <= '0;
            unf_count  <= '0;
            jump_count <= '0;
            alarm      <= 1'b0;
        end else begin
            ovf_pulse  <= is_ovf;
            unf_pulse  <= is_unf;
            jump_pulse <= is_jump;
            if (cnt_valid) begin
                last_cnt <= cnt_in;
            end
            if (is_ovf) begin
                ovf_count <= ovf_inc;
            end
            if (is_unf) begin
                unf_count <= unf_inc;
            end
            if (is_jump) begin
                jump_count <= jump_inc;
            end
            if (trigger) begin
                state <= ALARM;
                alarm <= 1'b1;
            end else if (state == ALARM && alarm_ack) begin
                state <= TRACK;
                alarm <= 1'b0;
            end else if (state == EMPTY && cnt_valid) begin
                state <= TRACK;
            end
        end
    end

endmodule
